// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock, LSB slice first, with
// valid/ready handshakes on the operand and result sides.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [DIGIT-1:0]   w_slc_sum;
  logic               w_slc_cout;
  logic               w_accept;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign w_accept = r_in_ready & in_valid;

  // Operand registers shift right each CALC cycle, so the active slice is always the low DIGIT bits.
  always_comb begin : ripple
    logic [1:0] v_fa;
    logic       v_c;
    v_c       = r_carry;
    v_fa      = 2'b00;
    w_slc_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      v_fa         = full_add(r_a[i], r_b[i], v_c);
      w_slc_sum[i] = v_fa[0];
      v_c          = v_fa[1];
    end
    w_slc_cout = v_c;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == LAST) w_next = S_DONE;
        else               w_next = S_CALC;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Operand capture and per-slice accumulation; results hold outside CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_slc_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      for (int k = 0; k < N; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_sum[k*DIGIT +: DIGIT] <= w_slc_sum;
        end
      end
      if (r_cnt == LAST) begin
        r_cout <= w_slc_cout;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: one instance with DIGIT=1 and one with DIGIT=4,
// each with its own expected-result queue and monitor.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv1, rdy1, ov1, or1, c1, co1;
  logic [7:0] a1, b1, s1;
  logic       iv4, rdy4, ov4, or4, c4, co4;
  logic [7:0] a4, b4, s4;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic pv1      = 1'b0;
  logic pv4      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the DIGIT=1 instance: compares on the first cycle of each out_valid.
  always @(negedge clk) begin
    if (rst_n && ov1 && !pv1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d1_spurious: got out_valid=1 expected no result pending");
      end else begin
        e1 = q1.pop_front();
        check("d1_sum", s1, e1.s);
        check("d1_cout", co1, e1.c);
        check("d1_latency", cyc - e1.acc, 8);
      end
    end
    pv1 <= rst_n && ov1;
  end

  // Monitor for the DIGIT=4 instance.
  always @(negedge clk) begin
    if (rst_n && ov4 && !pv4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d4_spurious: got out_valid=1 expected no result pending");
      end else begin
        e4 = q4.pop_front();
        check("d4_sum", s4, e4.s);
        check("d4_cout", co4, e4.c);
        check("d4_latency", cyc - e4.acc, 2);
      end
    end
    pv4 <= rst_n && ov4;
  end

  task automatic do_op(input bit d4, input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [7:0] es, input logic ec, input bit track);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (t < 50 && !(d4 ? rdy4 : rdy1)) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", d4 ? rdy4 : rdy1, 1);
    if (d4) begin
      a4 = ta; b4 = tb_v; c4 = tc; iv4 = 1'b1;
    end else begin
      a1 = ta; b1 = tb_v; c1 = tc; iv1 = 1'b1;
    end
    if (track) begin
      e.s   = es;
      e.c   = ec;
      e.acc = cyc + 1;
      if (d4) q4.push_back(e);
      else    q1.push_back(e);
    end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (t < 60 && (q1.size() != 0 || q4.size() != 0)) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results outstanding expected 0", q1.size() + q4.size());
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    iv1 = 1'b0; a1 = 8'h00; b1 = 8'h00; c1 = 1'b0; or1 = 1'b1;
    iv4 = 1'b0; a4 = 8'h00; b4 = 8'h00; c4 = 1'b0; or4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", rdy1, 1);
    check("rst_out_valid", ov1, 0);
    check("rst_sum", s1, 0);
    check("rst_cout", co1, 0);
    check("rst_d4_in_ready", rdy4, 1);
    check("rst_d4_out_valid", ov4, 0);
    rst_n = 1'b1;

    do_op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    drain();
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    drain();
    do_op(1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
    drain();
    do_op(1'b0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b1);
    drain();
    do_op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    drain();

    // Back-pressure: C8 + 64 = 0x12C.
    or1 = 1'b0;
    do_op(1'b0, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b1);
    t = 0;
    while (t < 20 && !ov1) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid_seen", ov1, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", ov1, 1);
      check("bp_sum", s1, 8'h2C);
      check("bp_cout", co1, 1);
      check("bp_in_ready", rdy1, 0);
      @(negedge clk);
    end
    or1 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", ov1, 0);
    check("bp_release_in_ready", rdy1, 1);
    check("bp_hold_sum", s1, 8'h2C);
    check("bp_hold_cout", co1, 1);
    drain();

    // Ignored in_valid during CALC.
    do_op(1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1);
    check("calc_in_ready", rdy1, 0);
    @(negedge clk);
    @(negedge clk);
    a1 = 8'h11;
    iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    a1 = 8'h00;
    drain();
    repeat (12) @(negedge clk);

    // Multi-bit digits.
    do_op(1'b1, 8'h9C, 8'h78, 1'b0, 8'h14, 1'b1, 1'b1);
    drain();
    do_op(1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);
    drain();
    do_op(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    drain();

    // Reset after three CALC edges aborts the operation.
    do_op(1'b0, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov1, 0);
    check("abort_sum", s1, 0);
    check("abort_cout", co1, 0);
    check("abort_in_ready", rdy1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle_in_ready", rdy1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
